if_fetch_stage: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the IF/ID pipeline register.
- Owns the PC register and next-PC selection: sequential, branch, j/jal and jr.
- Talks to the instruction memory through a variable-latency req/ack handshake.
- Presents PC_F and Instruction_F to IF/ID. Holds a fetched word across stalls and remembers a D-stage redirect when the delay-slot fetch is still outstanding.

---
 rtl/if_fetch_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage of a 5-stage MIPS pipeline. Owns the PC register
//   and next-PC selection, talks to a variable-latency instruction memory over
//   a req/ack handshake, and presents PC_F / Instruction_F to the IF/ID
//   register.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   En_F              : 1 = IF/ID loads this cycle, 0 = stall
//   NPC_Sel           : 00 PC+4, 01 branch, 10 j/jal, 11 jr (from D)
//   Branch_Taken      : branch condition from D (used when NPC_Sel=01)
//   Branch_Target_D   : branch target computed in D
//   Jump_Index_D      : instr_index field of j/jal
//   PC_D              : PC of the instruction in D
//   RS_Value_D        : forwarded GPR[rs] for jr
//   im_req / im_addr  : instruction memory request and word index
//   im_rdata / im_ack : returned word and its one-cycle completion pulse
//   PC_F              : PC of the instruction being presented
//   Instruction_F     : fetched word, 0 (nop) when Valid_F=0
//   Valid_F           : Instruction_F holds a real instruction
//
// Handshake: im_req stays high with a stable im_addr while in ST_REQ; the
// cycle in which im_ack=1 completes the request and im_rdata is valid only in
// that cycle. im_ack outside ST_REQ is ignored.
// -----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              En_F,
  input  logic [1:0]        NPC_Sel,
  input  logic              Branch_Taken,
  input  logic [31:0]       Branch_Target_D,
  input  logic [25:0]       Jump_Index_D,
  input  logic [31:0]       PC_D,
  input  logic [31:0]       RS_Value_D,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_rdata,
  input  logic              im_ack,
  output logic [31:0]       PC_F,
  output logic [31:0]       Instruction_F,
  output logic              Valid_F
);

  localparam logic [0:0] ST_REQ  = 1'b0;
  localparam logic [0:0] ST_HAVE = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        pend_valid_q, pend_valid_d;

  logic        ack_live;
  logic        live_redirect;
  logic [31:0] live_target;
  logic [31:0] npc;
  logic [31:0] pc_offset;

  // An ack only counts while a request is outstanding.
  assign ack_live = (state_q == ST_REQ) && im_ack;

  assign Valid_F       = buf_valid_q | ack_live;
  assign Instruction_F = buf_valid_q ? buf_q : (ack_live ? im_rdata : 32'h0);
  assign PC_F          = pc_q;
  assign im_req        = (state_q == ST_REQ);

  // Word index relative to the memory base; wraps modulo 2^ADDR_W.
  assign pc_offset = pc_q - RESET_PC;
  assign im_addr   = pc_offset[ADDR_W+1:2];

  always_comb begin
    live_redirect = 1'b0;
    live_target   = pc_q + 32'd4;
    case (NPC_Sel)
      2'b01: begin
        live_redirect = Branch_Taken;
        if (Branch_Taken) live_target = Branch_Target_D;
      end
      2'b10: begin
        live_redirect = 1'b1;
        live_target   = {PC_D[31:28], Jump_Index_D, 2'b00};
      end
      2'b11: begin
        live_redirect = 1'b1;
        live_target   = {RS_Value_D[31:2], 2'b00};
      end
      default: ;
    endcase
  end

  // A remembered redirect wins over whatever D presents now.
  assign npc = pend_valid_q ? pend_target_q : live_target;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_d         = buf_q;
    buf_valid_d   = buf_valid_q;
    pend_target_d = pend_target_q;
    pend_valid_d  = pend_valid_q;

    if (Valid_F && En_F) begin
      pc_d         = npc;
      buf_valid_d  = 1'b0;
      state_d      = ST_REQ;
      pend_valid_d = 1'b0;
    end else if (Valid_F) begin
      // Stall: park a freshly acked word so IF/ID sees it unchanged.
      if (ack_live) begin
        buf_d       = im_rdata;
        buf_valid_d = 1'b1;
        state_d     = ST_HAVE;
      end
    end else if (En_F && live_redirect && !pend_valid_q) begin
      // The jump leaves D while its delay slot is still being fetched;
      // keep the target so the advance after the delay slot uses it.
      pend_target_d = live_target;
      pend_valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      buf_q         <= 32'h0;
      buf_valid_q   <= 1'b0;
      pend_target_q <= 32'h0;
      pend_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      buf_q         <= buf_d;
      buf_valid_q   <= buf_valid_d;
      pend_target_q <= pend_target_d;
      pend_valid_q  <= pend_valid_d;
    end
  end

endmodule
